// File: rtl/segway_pkg.sv
// Shared constants and state types for the Segway authorisation path.
// Holds the UART command bytes, the default bit period and the FSM state encodings.
package segway_pkg;

    localparam int         BAUD_CYCLES = 2604;   // 50 MHz / 19200 baud
    localparam logic [7:0] CMD_GO      = 8'h67;  // 'g'
    localparam logic [7:0] CMD_STOP    = 8'h73;  // 's'

    localparam int BAUD_W = 12;
    localparam int BIT_W  = 4;

    // PWR1 and PWR2 both have bit 0 set, so "powered" is a single flop.
    typedef enum logic [1:0] {
        OFF  = 2'b00,
        PWR1 = 2'b01,
        PWR2 = 2'b11
    } auth_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: double-flop synchroniser, mid-bit sampling, one-byte holding register.
// A frame with a low stop bit is dropped without touching rx_data or rdy.
module uart_rx #(
    parameter int BAUD_CYCLES = segway_pkg::BAUD_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);
    import segway_pkg::rx_state_t, segway_pkg::IDLE, segway_pkg::RECV;
    import segway_pkg::BAUD_W, segway_pkg::BIT_W;

    localparam logic [BAUD_W-1:0] FULL = BAUD_W'(BAUD_CYCLES);
    localparam logic [BAUD_W-1:0] HALF = BAUD_W'(BAUD_CYCLES / 2);

    rx_state_t         state, nxt;
    logic              rx_ff1, rx_sync;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [7:0]        sr;
    logic              start_det, sample, frame_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // bit_cnt: 0 = start, 1..8 = data, 9 = stop
    always_comb begin
        nxt       = state;
        start_det = 1'b0;
        sample    = 1'b0;
        frame_ok  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    nxt       = RECV;
                    start_det = 1'b1;
                end
            end
            RECV: begin
                if (baud_cnt == BAUD_W'(1)) begin
                    sample = 1'b1;
                    if (bit_cnt == BIT_W'(0) && rx_sync) begin
                        nxt = IDLE;
                    end else if (bit_cnt == BIT_W'(9)) begin
                        nxt      = IDLE;
                        frame_ok = rx_sync;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1   <= 1'b1;
            rx_sync  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= 8'h00;
            rx_data  <= 8'h00;
            rdy      <= 1'b0;
        end else begin
            rx_ff1  <= RX;
            rx_sync <= rx_ff1;

            if (start_det) begin
                baud_cnt <= HALF;
                bit_cnt  <= '0;
            end else if (state == RECV) begin
                if (sample) begin
                    baud_cnt <= FULL;
                    bit_cnt  <= bit_cnt + BIT_W'(1);
                end else begin
                    baud_cnt <= baud_cnt - BAUD_W'(1);
                end
            end

            // LSB arrives first, so shifting in at the MSB leaves it at bit 0
            if (sample && bit_cnt >= BIT_W'(1) && bit_cnt <= BIT_W'(8))
                sr <= {rx_sync, sr[7:1]};

            if (frame_ok)
                rx_data <= sr;

            if (clr_rdy || start_det) rdy <= 1'b0;
            else if (frame_ok)        rdy <= 1'b1;
        end
    end

endmodule

// File: rtl/auth_blk.sv
// Segway power authorisation: UART commands plus rider presence drive an OFF/PWR1/PWR2 FSM.
// Every received byte is consumed in the cycle after rdy rises, whether or not it is acted on.
module auth_blk #(
    parameter int         BAUD_CYCLES = segway_pkg::BAUD_CYCLES,
    parameter logic [7:0] CMD_GO      = segway_pkg::CMD_GO,
    parameter logic [7:0] CMD_STOP    = segway_pkg::CMD_STOP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic [7:0] rx_data,
    output logic       rx_rdy
);
    import segway_pkg::auth_state_t, segway_pkg::OFF, segway_pkg::PWR1, segway_pkg::PWR2;

    auth_state_t state, nxt;
    logic        clr_rdy;
    logic        is_go, is_stop;

    uart_rx #(.BAUD_CYCLES(BAUD_CYCLES)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rx_rdy)
    );

    assign is_go   = rx_rdy && (rx_data == CMD_GO);
    assign is_stop = rx_rdy && (rx_data == CMD_STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= OFF;
        else        state <= nxt;
    end

    always_comb begin
        nxt     = state;
        clr_rdy = rx_rdy;
        case (state)
            OFF:  if (is_go) nxt = PWR1;
            PWR1: if (is_stop) nxt = rider_off ? OFF : PWR2;
            PWR2: begin
                // dismount wins over a late GO
                if (rider_off)  nxt = OFF;
                else if (is_go) nxt = PWR1;
            end
            default: nxt = OFF;
        endcase
    end

    // Equals (state != OFF) under this encoding, taken straight from one flop
    assign pwr_up = state[0];

endmodule

// File: tb/tb_auth_blk.sv
// Bench for auth_blk: directed command sequences then random frames, all checked against
// a byte-level model of the authorisation rules.
module tb_auth_blk;

    localparam int         BAUD = 16;
    localparam logic [7:0] GO   = 8'h67;
    localparam logic [7:0] STOP = 8'h73;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       rider_off = 1'b0;
    logic       pwr_up, rx_rdy;
    logic [7:0] rx_data;

    int         total = 0;
    int         bad = 0;
    int         mode = 0;            // 0 off, 1 powered, 2 powered awaiting dismount
    logic [7:0] last_data = 8'h00;

    always #5 clk = ~clk;

    auth_blk #(.BAUD_CYCLES(BAUD), .CMD_GO(GO), .CMD_STOP(STOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .rider_off (rider_off),
        .pwr_up    (pwr_up),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // What one accepted byte does to the authorisation mode
    function automatic int next_mode(input int m, input logic [7:0] b, input logic rider);
        if (m == 0) return (b == GO) ? 1 : 0;
        if (m == 1) return (b == STOP) ? (rider ? 0 : 2) : 1;
        if (rider)  return 0;
        return (b == GO) ? 1 : 2;
    endfunction

    task automatic bit_out(input logic v);
        RX = v;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_b);
        bit seen = 1'b0;
        int old  = mode;
        @(negedge clk);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        RX = stop_b;
        for (int c = 0; c < 2*BAUD && !seen; c++) begin
            if (c == (3*BAUD)/4) RX = 1'b1;
            @(negedge clk);
            if (rx_rdy) seen = 1'b1;
        end
        RX = 1'b1;
        if (stop_b) begin
            chk("rdy_seen", 32'(seen), 32'(1));
            if (seen) begin
                chk("rx_data", 32'(rx_data), 32'(b));
                chk("pwr_hold", 32'(pwr_up), 32'(old != 0));
                mode      = next_mode(old, b, rider_off);
                last_data = b;
                @(negedge clk);
                chk("rdy_clr", 32'(rx_rdy), 32'(0));
                chk("pwr_up", 32'(pwr_up), 32'(mode != 0));
            end
        end else begin
            chk("ferr_rdy", 32'(seen), 32'(0));
            chk("ferr_data", 32'(rx_data), 32'(last_data));
            chk("ferr_pwr", 32'(pwr_up), 32'(mode != 0));
        end
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic set_rider(input logic v);
        @(negedge clk);
        rider_off = v;
        if (mode == 2 && v) mode = 0;
        @(negedge clk);
        chk("rider_pwr", 32'(pwr_up), 32'(mode != 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pwr", 32'(pwr_up), 32'(0));
        chk("rst_rdy", 32'(rx_rdy), 32'(0));
        chk("rst_data", 32'(rx_data), 32'(0));
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        mode      = 0;
        last_data = 8'h00;
    endtask

    // Reset lands in the middle of data bit 4; nothing from that frame may surface
    task automatic abort_frame(input logic [7:0] b);
        bit seen = 1'b0;
        @(negedge clk);
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(b[i]);
        RX = b[4];
        repeat (BAUD/2) @(negedge clk);
        do_reset();
        for (int c = 0; c < 3*BAUD; c++) begin
            @(negedge clk);
            if (rx_rdy) seen = 1'b1;
        end
        chk("abort_norx", 32'(seen), 32'(0));
        chk("abort_pwr", 32'(pwr_up), 32'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       sb;
        do_reset();

        send(GO, 1'b1);            // OFF -> PWR1
        set_rider(1'b0);
        send(STOP, 1'b1);          // rider on: PWR2, still powered
        set_rider(1'b1);           // dismount -> OFF
        send(GO, 1'b1);            // GO from OFF regardless of rider
        send(STOP, 1'b1);          // rider off: straight to OFF
        set_rider(1'b0);
        send(8'h41, 1'b1);         // junk in OFF
        send(STOP, 1'b1);          // STOP in OFF ignored
        send(GO, 1'b1);
        send(8'h5A, 1'b0);         // framing error
        abort_frame(GO);
        send(GO, 1'b1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 3) set_rider(1'($urandom_range(0, 1)));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = GO;
                4, 5, 6, 7: b = STOP;
                default:    b = 8'($urandom);
            endcase
            sb = ($urandom_range(0, 7) != 0);
            send(b, sb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/auth_blk.md
AUTH_BLK -- requirements
Module: auth_blk

Interface
REQ-001 SHALL have parameter BAUD_CYCLES, default 2604, giving clocks per UART bit (50 MHz / 19200 baud).
REQ-002 SHALL have parameter CMD_GO, default 8'h67 ('g'), the power-up command byte.
REQ-003 SHALL have parameter CMD_STOP, default 8'h73 ('s'), the power-down command byte.
REQ-004 SHALL have port clk, input, 1, the single system clock, with all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-006 SHALL have port RX, input, 1, the asynchronous UART serial line, idle high.
REQ-007 SHALL have port rider_off, input, 1, asserted high when load cells report no rider.
REQ-008 SHALL have port pwr_up, output, 1, asserted high when the Segway is authorised to balance.
REQ-009 SHALL have port rx_data, output, 8, the last correctly framed byte (debug/observation).
REQ-010 SHALL have port rx_rdy, output, 1, asserted high when rx_data holds an unconsumed byte.

Function
REQ-011 SHALL pass RX through two flops, with the first preset to 1, before any use.
REQ-012 SHALL have a receiver with states IDLE and RECV.
REQ-013 SHALL move IDLE->RECV on the first synchronised RX low, loading the baud counter with BAUD_CYCLES/2 so that sampling falls mid-bit.
REQ-014 SHALL, in RECV, sample at each baud-counter expiry and then reload BAUD_CYCLES.
REQ-015 SHALL take 10 samples per frame: start, 8 data bits (LSB first, shifted in from the MSB end), then stop.
REQ-016 SHALL return the receiver to IDLE at the stop-bit sample.
REQ-017 SHALL, on that sample with stop=1, update rx_data and set rx_rdy on the next clock.
REQ-018 SHALL, on that sample with stop=0 (framing error), leave rx_data and rx_rdy unchanged.
REQ-019 SHALL return to IDLE without receiving a byte if the start-bit sample reads 1 (glitch).
REQ-020 SHALL clear rx_rdy on internal clr_rdy or on a new start-bit detection, with clear taking priority over a simultaneous set.
REQ-021 SHALL have an authorisation FSM with states OFF, PWR1 and PWR2, where pwr_up = (state != OFF) is registered-state decoded and glitch-free.
REQ-022 SHALL make OFF->PWR1 when rx_rdy and rx_data==CMD_GO.
REQ-023 SHALL make PWR1->OFF when rx_rdy and rx_data==CMD_STOP and rider_off.
REQ-024 SHALL make PWR1->PWR2 when rx_rdy and rx_data==CMD_STOP and !rider_off.
REQ-025 SHALL make PWR2->OFF when rider_off.
REQ-026 SHALL make PWR2->PWR1 when rx_rdy and rx_data==CMD_GO and !rider_off.
REQ-027 SHALL give rider_off priority over a simultaneous CMD_GO while in PWR2, so the FSM goes to OFF.
REQ-028 SHALL have the FSM assert clr_rdy for one clock whenever rx_rdy is high, in every state; any byte other than the legal command for the current state is consumed and ignored.
REQ-029 SHALL make pwr_up change exactly one clock after the rx_rdy rising edge, or one clock after the rider_off rise in PWR2.
REQ-030 SHALL keep rider_off from affecting state while in OFF or PWR1, except as the qualifier in REQ-023/REQ-024.

Reset
REQ-031 SHALL, while rst_n is low, asynchronously force pwr_up=0, rx_rdy=0, rx_data=8'h00, receiver IDLE, FSM OFF, baud and bit counters 0, and synchroniser flops 1.
REQ-032 SHALL abandon a frame in progress at reset mid-frame, with no partial byte delivered.
REQ-033 SHALL require a fresh falling edge on RX after reset release before reception starts.

Structure
REQ-034 SHALL place CMD_GO, CMD_STOP, the default BAUD_CYCLES, and the auth_state_t enum {OFF,PWR1,PWR2} in shared package segway_pkg.
REQ-035 SHALL instantiate receiver sub-module uart_rx (ports clk, rst_n, RX, clr_rdy, rx_data, rdy) inside auth_blk, with auth_blk itself holding only the FSM.
REQ-036 SHALL size the baud counter at 12 bits and the bit counter at 4 bits.

Verification
REQ-037 SHALL cover this case: after reset, send 8'h67 -> rx_rdy pulses, rx_data==8'h67, pwr_up=1 one clock after rx_rdy rise, and rx_rdy cleared the following clock.
REQ-038 SHALL cover this case: pwr_up=1, rider_off=0, send 8'h73 -> pwr_up stays 1 (PWR2); then raise rider_off -> pwr_up=0 within 1 clock.
REQ-039 SHALL cover this case: pwr_up=1, rider_off=1, send 8'h73 -> pwr_up=0 one clock after rx_rdy.
REQ-040 SHALL cover this case: in OFF, send 8'h41 then 8'h73 -> pwr_up stays 0 and each byte is consumed (rx_rdy low 2 clocks later).
REQ-041 SHALL cover this case: send a frame with stop bit driven 0 -> rx_rdy never asserts and rx_data keeps its prior value.
REQ-042 SHALL cover this case: assert rst_n=0 at data bit 4 of an 8'h67 frame, release, then send 8'h67 -> only the second frame is received and pwr_up=1.
